// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_pkg : MDU opcode encoding and default multicycle latencies.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_arith : combinational mult/div datapath producing {hi,lo}.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_zero;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_div_u;
  logic [31:0] w_div_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;

  // Signed product from full-width sign-extended operands; low 64 bits are exact.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  assign w_b_zero = (i_b == 32'd0);
  assign w_abs_a  = i_a[31] ? (~i_a + 32'd1) : i_a;
  assign w_abs_b  = i_b[31] ? (~i_b + 32'd1) : i_b;

  // Divisors are forced nonzero so the dividers never see zero; result is held below.
  assign w_div_u = w_b_zero ? 32'd1 : i_b;
  assign w_div_s = w_b_zero ? 32'd1 : w_abs_b;

  assign w_q_u   = i_a / w_div_u;
  assign w_r_u   = i_a % w_div_u;
  assign w_q_mag = w_abs_a / w_div_s;
  assign w_r_mag = w_abs_a % w_div_s;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_q_s = (i_a[31] ^ i_b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s = i_a[31] ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    o_result = {i_hi, i_lo};
    case (i_op)
      MDU_MULT:  o_result = w_prod_s;
      MDU_MULTU: o_result = w_prod_u;
      MDU_DIV:   if (!w_b_zero) o_result = {w_r_s, w_q_s};
      MDU_DIVU:  if (!w_b_zero) o_result = {w_r_u, w_q_u};
      default:   o_result = {i_hi, i_lo};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | e_mdu : E-stage multicycle multiply/divide unit owning HI/LO.       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  E_CU_MDU_op,
  input  logic        E_CU_MDU_start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_MDU_busy,
  output logic [31:0] E_MDU_Out,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_MULT_N   = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_N    = c_CNT_W'(DIV_CYCLES);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic [31:0]        w_hi_nxt;
  logic [31:0]        w_lo_nxt;
  logic [31:0]        w_pend_hi_nxt;
  logic [31:0]        w_pend_lo_nxt;
  logic [0:0]         w_state;
  logic               w_is_arith;
  logic               w_is_div;
  logic               w_accept;
  logic               w_idle_ok;
  logic [63:0]        w_arith;

  mdu_arith u_arith (
    .i_op     (E_CU_MDU_op),
    .i_a      (E_A),
    .i_b      (E_B),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_arith)
  );

  // The down-counter is the state: nonzero means an operation is in flight.
  assign w_state    = (r_cnt != c_CNT_ZERO) ? c_ST_BUSY : c_ST_IDLE;
  assign w_idle_ok  = (w_state == c_ST_IDLE) && !req;
  assign w_is_arith = (E_CU_MDU_op >= MDU_MULT) && (E_CU_MDU_op <= MDU_DIVU);
  assign w_is_div   = (E_CU_MDU_op == MDU_DIV) || (E_CU_MDU_op == MDU_DIVU);
  assign w_accept   = E_CU_MDU_start && w_is_arith && w_idle_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= c_CNT_ZERO;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (w_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt     = w_is_div ? c_DIV_N : c_MULT_N;
          w_pend_hi_nxt = w_arith[63:32];
          w_pend_lo_nxt = w_arith[31:0];
        end else if (w_idle_ok && (E_CU_MDU_op == MDU_MTHI)) begin
          w_hi_nxt = E_A;
        end else if (w_idle_ok && (E_CU_MDU_op == MDU_MTLO)) begin
          w_lo_nxt = E_A;
        end
      end
      default: begin
        // req is deliberately ignored here: the running op is already committed.
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_hi_nxt = r_pend_hi;
          w_lo_nxt = r_pend_lo;
        end
      end
    endcase
  end

  always_comb begin
    E_MDU_busy = (w_state == c_ST_BUSY);
    E_HI       = r_hi;
    E_LO       = r_lo;
    case (E_CU_MDU_op)
      MDU_MFHI: E_MDU_Out = r_hi;
      MDU_MFLO: E_MDU_Out = r_lo;
      default:  E_MDU_Out = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_e_mdu : directed self-checking bench for e_mdu.                  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic [3:0]  op    = MDU_NONE;
  logic        start = 1'b0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy;
  logic [31:0] mdu_out;
  logic [31:0] hi;
  logic [31:0] lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .E_CU_MDU_op    (op),
    .E_CU_MDU_start (start),
    .E_A            (a),
    .E_B            (b),
    .E_MDU_busy     (busy),
    .E_MDU_Out      (mdu_out),
    .E_HI           (hi),
    .E_LO           (lo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          n;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one instruction into E for exactly one rising edge.
  task automatic issue(input logic [3:0] o, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic r);
    op = o; start = s; a = x; b = y; req = r;
    @(posedge clk);
    #1;
    op = MDU_NONE; start = 1'b0; req = 1'b0;
  endtask

  // Count busy cycles on falling edges; HI/LO must hold their old values while busy.
  task automatic wait_done(input string name, input logic [31:0] hi0, input logic [31:0] lo0,
                           input int req_at, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == req_at) req = 1'b1;
      if (!busy) break;
      chk({name, " hi_hold"}, hi, hi0);
      chk({name, " lo_hold"}, lo, lo0);
      n++;
    end
    req = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] h0, l0;

    vecs[0] = '{"mult_neg",  MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vecs[1] = '{"multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[2] = '{"divu_big",  MDU_DIVU,  32'd7,        32'hFFFFFFFF, 32'd7,        32'd0,        DC};
    vecs[3] = '{"div_neg7",  MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[4] = '{"div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
    vecs[5] = '{"div_7_m2",  MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC};
    vecs[6] = '{"mult_16",   MDU_MULT,  32'h00010000, 32'h00010000, 32'd1,        32'd0,        MC};

    #1 reset = 1'b0;
    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst out", mdu_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      h0 = hi; l0 = lo;
      issue(vecs[i].op, 1'b1, vecs[i].a, vecs[i].b, 1'b0);
      wait_done(vecs[i].name, h0, l0, -1, n);
      chk({vecs[i].name, " busy_cycles"}, n, vecs[i].n);
      chk({vecs[i].name, " hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, " lo"}, lo, vecs[i].exp_lo);
    end

    // Reads are combinational from HI=1, LO=0 left by the last vector.
    op = MDU_MFHI; #1 chk("mfhi out", mdu_out, 32'd1);
    op = MDU_MFLO; #1 chk("mflo out", mdu_out, 32'd0);
    op = MDU_NONE; #1 chk("none out", mdu_out, 32'd0);
    op = 4'd15;    #1 chk("op15 out", mdu_out, 32'd0);
    op = MDU_NONE;
    @(negedge clk);

    // Divide by zero keeps HI/LO but still occupies the divider latency.
    issue(MDU_MTHI, 1'b0, 32'h11, 32'd0, 1'b0);
    issue(MDU_MTLO, 1'b0, 32'h22, 32'd0, 1'b0);
    @(negedge clk);
    chk("mthi hi", hi, 32'h11);
    chk("mtlo lo", lo, 32'h22);
    issue(MDU_DIV, 1'b1, 32'd5, 32'd0, 1'b0);
    wait_done("div0", 32'h11, 32'h22, -1, n);
    chk("div0 busy_cycles", n, DC);
    chk("div0 hi", hi, 32'h11);
    chk("div0 lo", lo, 32'h22);

    // Flushed instructions must leave no trace.
    issue(MDU_MULT, 1'b1, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    chk("req mult busy", {31'd0, busy}, 32'd0);
    chk("req mult hi", hi, 32'h11);
    chk("req mult lo", lo, 32'h22);
    issue(MDU_MTHI, 1'b0, 32'hDEAD, 32'd0, 1'b1);
    @(negedge clk);
    chk("req mthi hi", hi, 32'h11);

    // req arriving mid-operation does not cancel it; MTLO while busy is ignored.
    issue(MDU_MULT, 1'b1, 32'hFFFFFFFE, 32'd3, 1'b0);
    op = MDU_MTLO; a = 32'h5555;
    @(posedge clk); #1 op = MDU_NONE;
    wait_done("req_mid", 32'h11, 32'h22, 1, n);
    chk("req_mid busy_cycles", n, MC - 1);
    chk("req_mid hi", hi, 32'hFFFFFFFF);
    chk("req_mid lo", lo, 32'hFFFFFFFA);

    // Asynchronous reset in the middle of a divide.
    issue(MDU_DIV, 1'b1, 32'd100, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    #4 reset = 1'b1;
    @(negedge clk);
    issue(MDU_MULT, 1'b1, 32'h00010000, 32'h00010000, 1'b0);
    wait_done("post_rst", 32'd0, 32'd0, -1, n);
    chk("post_rst busy_cycles", n, MC);
    chk("post_rst hi", hi, 32'd1);
    chk("post_rst lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage, directly downstream of the D→E pipeline register.
- Consumes the registered MDU opcode and start strobe, plus forwarded rs/rt operands.
- Runs multicycle mult/div into HI/LO, serves mfhi/mflo reads, and exports a busy flag to the hazard unit (HCU).
- Honours the exception request `req`, so a flushed instruction never alters HI/LO.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu, in cycles (>=1)
DIV_CYCLES, 10, busy duration for div/divu, in cycles (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  exception/interrupt flush request from CP0; suppresses side effects of the E-stage instruction
E_CU_MDU_op  input  4  MDU opcode from D→E register
E_CU_MDU_start  input  1  high for mult/multu/div/divu in E
E_A  input  32  forwarded rs value
E_B  input  32  forwarded rt value
E_MDU_busy  output  1  multicycle operation in progress
E_MDU_Out  output  32  HI for mfhi, LO for mflo, else 0
E_HI  output  32  architectural HI
E_LO  output  32  architectural LO

Behaviour:
- Op encoding (4-bit): 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Values 9..15 are treated as NONE.
- Reset (reset==0, async): HI=0, LO=0, pending HI/LO=0, counter=0, busy=0. This applies mid-operation too: any in-flight result is discarded.
- State machine: IDLE and BUSY. Busy is encoded as counter != 0.
- Accept condition: start && !req && !busy && op in 1..4.
- On accept at edge t:
  - Compute the result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - E_MDU_busy is high from t through t+N-1.
- BUSY: counter decrements each edge. At the edge where counter==1, HI/LO <= pending and busy drops.
- Resulting visibility: HI/LO change exactly N edges after accept, and E_MDU_busy is high for exactly N cycles.
- start while busy, or start with req: ignored, with no state change. HCU must stall so this never occurs architecturally.
- MTHI/MTLO: HI<=E_A (MTHI) or LO<=E_A (MTLO) at the edge when op matches, !req and !busy. They are ignored while busy.
- MFHI/MFLO: E_MDU_Out is combinational from the current HI/LO, not from pending values. While busy, HCU stalls the consumer.
- req during BUSY does not cancel: the operation belongs to an older, committed instruction and completes normally.
- Arithmetic:
  - MULT: signed 32x32→64, HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32→64, same split.
  - DIV: signed, LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divisor 0 (div or divu): pending = current HI/LO, so HI/LO are unchanged, but busy still lasts DIV_CYCLES.
- HCU hazard term: (E_MDU_busy | E_CU_MDU_start) && D-stage instruction is an MDU op. The start term is ORed inside the HCU, not inside this block.

Decomposition:
- mdu_pkg: op encoding constants (MDU_NONE..MDU_MTLO), default latency constants.
- Sub-module mdu_arith: purely combinational. Takes op, A and B; produces the 64-bit {hi,lo} result, including signed/unsigned handling and the divide-by-zero hold. e_mdu instantiates it once and owns the counter, HI/LO and pending registers.

Test Plan:
- MULT: A=0xFFFFFFFE (-2), B=3, start pulse → busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged before that edge.
- DIVU: A=7, B=0xFFFFFFFF → busy 10 cycles, then LO=0, HI=7. DIV with A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV with A=0x80000000, B=-1 → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV with B=0 → busy 10 cycles, HI=0x11, LO=0x22 after.
- req: start MULT with req=1 → busy stays 0, HI/LO unchanged. MTHI with req=1 → HI unchanged. Start MULT, assert req at cycle 2 of busy → result still lands at cycle 5.
- Reset mid-op: start DIV, drop reset low at cycle 4 (async, off-edge) → busy=0, HI=LO=0 immediately. After release, a new start works normally.
- MFHI/MFLO: after MULT 0x10000×0x10000 completes → op=MFHI gives E_MDU_Out=1, op=MFLO gives 0, op=NONE gives 0.
